// File: rtl/axi_arb_pkg.sv
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared types and constants for the two-master AXI4-Lite
//               arbiter (FSM states, transaction type, master count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

  localparam int NUM_MASTERS = 2;

  // One transaction in flight at a time; the state names the phase it is in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_XFER = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } arb_state_e;

  typedef enum logic {
    TXN_WR = 1'b0,
    TXN_RD = 1'b1
  } txn_type_e;

endpackage : axi_arb_pkg

`default_nettype wire

// File: rtl/axi_arb_2to1_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester grant selector. Round-robin by default: when
//               both request, the pointer names the winner. With
//               AXI_ARB_FIXED_PRIO_EN defined, requester 0 always wins and
//               the pointer input is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   rr_ptr,
  output logic                   grant
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Pointer has no meaning in fixed-priority mode.
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  // Requester 1 only wins when requester 0 is silent.
  always_comb begin
    grant = ~req[0] & req[1];
  end
`else
  // Contention resolved by the pointer; otherwise the lone requester wins.
  always_comb begin
    if (&req) grant = rr_ptr;
    else      grant = ~req[0] & req[1];
  end
`endif

endmodule : rr_arb2

`default_nettype wire

// File: rtl/axi_arb_2to1.sv
// ============================================================================
// Module      : axi_arb_2to1
// Description : Two-master AXI4-Lite arbiter in front of a single-port memory
//               slave. One transaction (read or write) is in flight at a time,
//               from grant to response. Writes beat reads from the same
//               master. Build option: AXI_ARB_FIXED_PRIO_EN selects fixed
//               priority (m0 wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_arb_2to1
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  // master 0
  input  logic                m0_axi_awvalid,
  output logic                m0_axi_awready,
  input  logic [ADDR_W-1:0]   m0_axi_awaddr,
  input  logic [2:0]          m0_axi_awprot,
  input  logic                m0_axi_wvalid,
  output logic                m0_axi_wready,
  input  logic [DATA_W-1:0]   m0_axi_wdata,
  input  logic [DATA_W/8-1:0] m0_axi_wstrb,
  output logic                m0_axi_bvalid,
  input  logic                m0_axi_bready,
  input  logic                m0_axi_arvalid,
  output logic                m0_axi_arready,
  input  logic [ADDR_W-1:0]   m0_axi_araddr,
  input  logic [2:0]          m0_axi_arprot,
  output logic                m0_axi_rvalid,
  input  logic                m0_axi_rready,
  output logic [DATA_W-1:0]   m0_axi_rdata,
  // master 1
  input  logic                m1_axi_awvalid,
  output logic                m1_axi_awready,
  input  logic [ADDR_W-1:0]   m1_axi_awaddr,
  input  logic [2:0]          m1_axi_awprot,
  input  logic                m1_axi_wvalid,
  output logic                m1_axi_wready,
  input  logic [DATA_W-1:0]   m1_axi_wdata,
  input  logic [DATA_W/8-1:0] m1_axi_wstrb,
  output logic                m1_axi_bvalid,
  input  logic                m1_axi_bready,
  input  logic                m1_axi_arvalid,
  output logic                m1_axi_arready,
  input  logic [ADDR_W-1:0]   m1_axi_araddr,
  input  logic [2:0]          m1_axi_arprot,
  output logic                m1_axi_rvalid,
  input  logic                m1_axi_rready,
  output logic [DATA_W-1:0]   m1_axi_rdata,
  // memory slave
  output logic                mem_axi_awvalid,
  input  logic                mem_axi_awready,
  output logic [ADDR_W-1:0]   mem_axi_awaddr,
  output logic [2:0]          mem_axi_awprot,
  output logic                mem_axi_wvalid,
  input  logic                mem_axi_wready,
  output logic [DATA_W-1:0]   mem_axi_wdata,
  output logic [DATA_W/8-1:0] mem_axi_wstrb,
  input  logic                mem_axi_bvalid,
  output logic                mem_axi_bready,
  output logic                mem_axi_arvalid,
  input  logic                mem_axi_arready,
  output logic [ADDR_W-1:0]   mem_axi_araddr,
  output logic [2:0]          mem_axi_arprot,
  input  logic                mem_axi_rvalid,
  output logic                mem_axi_rready,
  input  logic [DATA_W-1:0]   mem_axi_rdata,
  // status
  output logic                arb_grant,
  output logic                arb_busy
);

  // Per-master views of the ports so the muxes can index by grant.
  logic [NUM_MASTERS-1:0] awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
  logic [NUM_MASTERS-1:0] awready_v, wready_v, bvalid_v, arready_v, rvalid_v;
  logic [ADDR_W-1:0]      awaddr_v [NUM_MASTERS];
  logic [ADDR_W-1:0]      araddr_v [NUM_MASTERS];
  logic [2:0]             awprot_v [NUM_MASTERS];
  logic [2:0]             arprot_v [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_v  [NUM_MASTERS];
  logic [DATA_W/8-1:0]    wstrb_v  [NUM_MASTERS];
  logic [DATA_W-1:0]      rdata_v  [NUM_MASTERS];

  assign awvalid_v = {m1_axi_awvalid, m0_axi_awvalid};
  assign wvalid_v  = {m1_axi_wvalid,  m0_axi_wvalid};
  assign bready_v  = {m1_axi_bready,  m0_axi_bready};
  assign arvalid_v = {m1_axi_arvalid, m0_axi_arvalid};
  assign rready_v  = {m1_axi_rready,  m0_axi_rready};

  assign awaddr_v[0] = m0_axi_awaddr;  assign awaddr_v[1] = m1_axi_awaddr;
  assign araddr_v[0] = m0_axi_araddr;  assign araddr_v[1] = m1_axi_araddr;
  assign awprot_v[0] = m0_axi_awprot;  assign awprot_v[1] = m1_axi_awprot;
  assign arprot_v[0] = m0_axi_arprot;  assign arprot_v[1] = m1_axi_arprot;
  assign wdata_v[0]  = m0_axi_wdata;   assign wdata_v[1]  = m1_axi_wdata;
  assign wstrb_v[0]  = m0_axi_wstrb;   assign wstrb_v[1]  = m1_axi_wstrb;

  assign m0_axi_awready = awready_v[0];  assign m1_axi_awready = awready_v[1];
  assign m0_axi_wready  = wready_v[0];   assign m1_axi_wready  = wready_v[1];
  assign m0_axi_bvalid  = bvalid_v[0];   assign m1_axi_bvalid  = bvalid_v[1];
  assign m0_axi_arready = arready_v[0];  assign m1_axi_arready = arready_v[1];
  assign m0_axi_rvalid  = rvalid_v[0];   assign m1_axi_rvalid  = rvalid_v[1];
  assign m0_axi_rdata   = rdata_v[0];    assign m1_axi_rdata   = rdata_v[1];

  arb_state_e             state;
  txn_type_e              txn;
  logic                   grant;
  logic                   busy;
  logic                   aw_done;
  logic                   w_done;
  logic [NUM_MASTERS-1:0] req;
  logic                   arb_sel;
  logic                   rr_ptr_in;
  logic                   aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                   txn_done;

  // A master requests if it presents either address channel.
  assign req = awvalid_v | arvalid_v;

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign rr_ptr_in = 1'b0;
`else
  logic rr_ptr;
  assign rr_ptr_in = rr_ptr;

  // Hand priority to the other master each time a transaction retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         rr_ptr <= 1'b0;
    else if (txn_done) rr_ptr <= ~grant;
  end
`endif

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .rr_ptr (rr_ptr_in),
    .grant  (arb_sel)
  );

  assign aw_hs = mem_axi_awvalid & mem_axi_awready;
  assign w_hs  = mem_axi_wvalid  & mem_axi_wready;
  assign ar_hs = mem_axi_arvalid & mem_axi_arready;
  assign b_hs  = mem_axi_bvalid  & mem_axi_bready;
  assign r_hs  = mem_axi_rvalid  & mem_axi_rready;

  // Final handshake of whichever transaction type was granted.
  assign txn_done = (txn == TXN_WR) ? ((state == ST_WR_RESP) & b_hs)
                                    : ((state == ST_RD_DATA) & r_hs);

  assign arb_grant = grant;
  assign arb_busy  = busy;

  // Transaction sequencer: grant, per-channel done tracking, response wait.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      txn     <= TXN_WR;
      grant   <= 1'b0;
      busy    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= arb_sel;
            busy  <= 1'b1;
            // A master holding both a write and a read is served write-first.
            if (awvalid_v[arb_sel]) begin
              txn   <= TXN_WR;
              state <= ST_WR_XFER;
            end else begin
              txn   <= TXN_RD;
              state <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (txn_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RD_ADDR: begin
          if (ar_hs) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (txn_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Route the granted master to the slave; everything else is held at 0.
  always_comb begin
    mem_axi_awvalid = 1'b0;
    mem_axi_awaddr  = '0;
    mem_axi_awprot  = '0;
    mem_axi_wvalid  = 1'b0;
    mem_axi_wdata   = '0;
    mem_axi_wstrb   = '0;
    mem_axi_bready  = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_araddr  = '0;
    mem_axi_arprot  = '0;
    mem_axi_rready  = 1'b0;
    awready_v = '0;
    wready_v  = '0;
    bvalid_v  = '0;
    arready_v = '0;
    rvalid_v  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) rdata_v[i] = '0;

    if (state != ST_IDLE) begin
      mem_axi_awaddr = awaddr_v[grant];
      mem_axi_awprot = awprot_v[grant];
      mem_axi_wdata  = wdata_v[grant];
      mem_axi_wstrb  = wstrb_v[grant];
      mem_axi_araddr = araddr_v[grant];
      mem_axi_arprot = arprot_v[grant];
    end

    case (state)
      ST_WR_XFER: begin
        // A completed channel is masked so it cannot be accepted twice.
        mem_axi_awvalid  = awvalid_v[grant] & ~aw_done;
        mem_axi_wvalid   = wvalid_v[grant]  & ~w_done;
        awready_v[grant] = mem_axi_awready  & ~aw_done;
        wready_v[grant]  = mem_axi_wready   & ~w_done;
      end
      ST_WR_RESP: begin
        bvalid_v[grant] = mem_axi_bvalid;
        mem_axi_bready  = bready_v[grant];
      end
      ST_RD_ADDR: begin
        mem_axi_arvalid  = arvalid_v[grant];
        arready_v[grant] = mem_axi_arready;
      end
      ST_RD_DATA: begin
        rvalid_v[grant] = mem_axi_rvalid;
        rdata_v[grant]  = mem_axi_rdata;
        mem_axi_rready  = rready_v[grant];
      end
      default: ;
    endcase
  end

endmodule : axi_arb_2to1

`default_nettype wire
